// File: rtl/conv_encoder_k3.sv
// -----------------------------------------------------------------------------
// conv_encoder_k3
//   Rate-1/2, constraint-length-3 convolutional encoder feeding the channel /
//   Viterbi decoder. Takes a serial frame of data bits over valid/ready, emits
//   one 2-bit parity symbol per bit, then flushes the trellis with two zero
//   tail bits so every frame ends (and the next one starts) in state 2'b00.
//
//   Optional feature macro: CONV_ENC_PUNCTURE_EN
//     defined   -> alternating keep masks from PUNC_PAT; punctured parity bits
//                  are driven 0 and flagged by out_keep.
//     undefined -> out_keep tied to 2'b11, plain rate 1/2.
//
// Ports
//   CLK        in   clock, all logic on posedge
//   RST        in   synchronous reset, active-high, overrides everything
//   in_valid   in   in_bit / in_last valid
//   in_ready   out  encoder accepts the input bit this cycle
//   in_bit     in   data bit u(n)
//   in_last    in   final data bit of the frame (qualified by in_valid)
//   out_valid  out  parities / out_keep / out_last valid
//   out_ready  in   downstream accepts the symbol
//   parities   out  {p1,p0} = {^(G_HI&{u,s0,s1}), ^(G_LO&{u,s0,s1})}
//   out_keep   out  per-bit transmit mask (1 = sent, 0 = punctured)
//   out_last   out  final tail symbol of the frame
//   busy       out  FSM not idle
// -----------------------------------------------------------------------------
module conv_encoder_k3 #(
  parameter logic [2:0] G_HI     = 3'b111,
  parameter logic [2:0] G_LO     = 3'b101,
  parameter logic [3:0] PUNC_PAT = 4'b1110
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] parities,
  output logic [1:0] out_keep,
  output logic       out_last,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2
  } fsm_t;

  fsm_t       state_q;
  fsm_t       state_d;

  // Trellis state {s1,s0}: s0 = u(n-1), s1 = u(n-2)
  logic [1:0] sreg_q;
  // Which of the two tail bits is next (0 = first, 1 = second)
  logic       tail_cnt_q;

  logic       load;
  logic       accept;
  logic       tail_load;
  logic       tail_done;
  logic       enc_p0;
  logic       u_p0;
  logic [1:0] sym_p0;
  logic [1:0] keep_p0;

  logic       vld_p1;
  logic [1:0] par_p1;
  logic [1:0] keep_p1;
  logic       last_p1;

  // Parity pair for input bit u from trellis state {s1,s0}; taps ordered
  // {u(n), u(n-1), u(n-2)}.
  function automatic logic [1:0] enc_sym(input logic u, input logic [1:0] st);
    logic [2:0] taps;
    taps = {u, st[0], st[1]};
    return {^(G_HI & taps), ^(G_LO & taps)};
  endfunction

  // Keep mask for the current puncturing phase: phase 0 uses the upper pair
  // of the pattern, phase 1 the lower pair.
  function automatic logic [1:0] punc_keep(input logic phase);
    return phase ? PUNC_PAT[1:0] : PUNC_PAT[3:2];
  endfunction

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          state_d = in_last ? TAIL : RUN;
        end
      end
      TAIL: begin
        if (tail_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs / handshake decode. The output register can take a new
  // symbol whenever it is empty or being drained this cycle; the same slot is
  // used by data bits and tail bits. RST masks in_ready so nothing appears
  // accepted while the block is held in reset.
  always_comb begin
    load      = !vld_p1 || out_ready;
    in_ready  = !RST && (state_q != TAIL) && load;
    tail_load = (state_q == TAIL) && load;
    tail_done = tail_load && tail_cnt_q;
    busy      = (state_q != IDLE);
  end

  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Stage p0: encode (data bit on accept, forced zero during the tail)
  // ---------------------------------------------------------------------------
  assign enc_p0 = accept || tail_load;
  assign u_p0   = accept ? in_bit : 1'b0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sreg_q <= 2'b00;
    end else if (enc_p0) begin
      sreg_q <= {sreg_q[0], u_p0};
    end
  end

  // Two zero bits walk the trellis back to 00, so no explicit clear is needed
  // at frame end; the counter wraps to 0 on the second tail load.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tail_cnt_q <= 1'b0;
    end else if (tail_load) begin
      tail_cnt_q <= ~tail_cnt_q;
    end
  end

`ifdef CONV_ENC_PUNCTURE_EN
  logic phase_q;

  // Phase alternates per emitted symbol and restarts at 0 for every frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_q <= 1'b0;
    end else if (enc_p0) begin
      phase_q <= tail_done ? 1'b0 : ~phase_q;
    end
  end

  assign keep_p0 = punc_keep(phase_q);
  assign sym_p0  = enc_sym(u_p0, sreg_q) & keep_p0;
`else
  // The pattern only matters when puncturing is built in.
  logic unused_punc;
  assign unused_punc = ^punc_keep(1'b0);

  assign keep_p0 = 2'b11;
  assign sym_p0  = enc_sym(u_p0, sreg_q);
`endif

  // ---------------------------------------------------------------------------
  // Stage p1: output register (holds everything stable under backpressure)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1  <= 1'b0;
      par_p1  <= 2'b00;
      keep_p1 <= 2'b11;
      last_p1 <= 1'b0;
    end else if (load) begin
      vld_p1  <= enc_p0;
      par_p1  <= enc_p0 ? sym_p0 : 2'b00;
      keep_p1 <= enc_p0 ? keep_p0 : 2'b11;
      last_p1 <= tail_done;
    end
  end

  assign out_valid = vld_p1;
  assign parities  = par_p1;
  assign out_last  = last_p1;
`ifdef CONV_ENC_PUNCTURE_EN
  assign out_keep  = keep_p1;
`else
  assign out_keep  = 2'b11;
`endif

endmodule

// File: tb/tb_conv_encoder_k3.sv
module tb_conv_encoder_k3;

  typedef struct packed {
    logic [1:0] par;
    logic [1:0] keep;
    logic       last;
  } sym_t;

  logic       CLK;
  logic       RST;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] parities;
  logic [1:0] out_keep;
  logic       out_last;
  logic       busy;

  int   checks = 0;
  int   errors = 0;
  sym_t exp_q[$];
  sym_t mdl[$];
  bit   tog = 0;
  int   cyc = 0;

  conv_encoder_k3 dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .parities  (parities),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: each symbol is the mod-2 sum of the current bit and the
  // previous one/two bits of the frame (zero before the frame start), per
  // generators 111 and 101. Tail = two zero bits appended when the frame
  // completes. Bits are given LSB-first in 'bits'.
  function automatic void model(input int n, input bit full, input logic [3:0] bits);
    int total;
    int seq[6];
    mdl.delete();
    total = full ? n + 2 : n;
    for (int k = 0; k < 6; k++) seq[k] = (k < n) ? int'(bits[k]) : 0;
    for (int k = 0; k < total; k++) begin
      sym_t s;
      int a1, a2;
      a1 = (k >= 1) ? seq[k-1] : 0;
      a2 = (k >= 2) ? seq[k-2] : 0;
      s.par[1] = ((seq[k] + a1 + a2) % 2) == 1;
      s.par[0] = ((seq[k] + a2) % 2) == 1;
`ifdef CONV_ENC_PUNCTURE_EN
      s.keep = (k % 2 == 0) ? 2'b11 : 2'b10;
      s.par  = s.par & s.keep;
`else
      s.keep = 2'b11;
`endif
      s.last = full && (k == total - 1);
      mdl.push_back(s);
    end
  endfunction

  function automatic void enqueue_model();
    foreach (mdl[i]) exp_q.push_back(mdl[i]);
  endfunction

  // out_ready: held at 1, or alternating 1,0,1,0 per cycle while tog is set
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      out_ready = tog ? ~cyc[0] : 1'b1;
    end
  end

  // Compare process: every symbol handshake checked against the model queue,
  // stalled symbols must stay stable, and input must be blocked during stalls.
  initial begin
    bit   stall;
    sym_t held;
    sym_t act;
    sym_t e;
    stall = 0;
    held  = '0;
    forever begin
      @(negedge CLK);
      act = '{par: parities, keep: out_keep, last: out_last};
      if (RST) begin
        stall = 0;
      end else begin
        if (stall) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_symbol", 32'(act), 32'(held));
        end
        if (out_valid && !out_ready) begin
          chk("in_ready_bp", 32'(in_ready), 32'd0);
          stall = 1;
          held  = act;
        end else begin
          stall = 0;
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_symbol: got %0h expected none at %0t", act, $time);
          end else begin
            e = exp_q.pop_front();
            checks--;
            chk("symbol {par,keep,last}", 32'(act), 32'(e));
          end
        end
      end
    end
  end

  task automatic drive_bit(input logic b, input logic last);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = last;
    @(negedge CLK);
    while (!in_ready && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no in_ready expected in_ready within 100 cycles");
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge CLK);
      t++;
    end
    repeat (2) @(posedge CLK);
    #1;
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_busy_idle"}, 32'(busy), 32'd0);
    chk({name, "_valid_idle"}, 32'(out_valid), 32'd0);
  endtask

  logic [1:0] pin_t2[6];
  logic [1:0] pin_t4a[3];

  initial begin
    RST      = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    in_last  = 1'b0;

    // T1: reset held two cycles with in_valid asserted
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_parities", 32'(parities), 32'd0);
    chk("rst_keep", 32'(out_keep), 32'd3);
    chk("rst_last", 32'(out_last), 32'd0);
    @(posedge CLK);
    #1;
    RST      = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;

    // Pin the model against hand-derived symbols
`ifdef CONV_ENC_PUNCTURE_EN
    pin_t2 = '{2'b11, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10};
`else
    pin_t2 = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
`endif
    pin_t4a = '{2'b11, 2'b10, 2'b11};
    model(4, 1'b1, 4'b1101);
    chk("pin_t2_len", 32'(mdl.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk("pin_t2_par", 32'(mdl[i].par), 32'(pin_t2[i]));
    chk("pin_t2_last5", 32'(mdl[5].last), 32'd1);
    chk("pin_t2_last3", 32'(mdl[3].last), 32'd0);
`ifdef CONV_ENC_PUNCTURE_EN
    chk("pin_t6_keep1", 32'(mdl[1].keep), 32'd2);
    chk("pin_t6_keep4", 32'(mdl[4].keep), 32'd3);
`endif
    model(1, 1'b1, 4'b0001);
`ifndef CONV_ENC_PUNCTURE_EN
    for (int i = 0; i < 3; i++) chk("pin_t4_par", 32'(mdl[i].par), 32'(pin_t4a[i]));
`endif
    chk("pin_t4_last", 32'(mdl[2].last), 32'd1);
    model(1, 1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) chk("pin_t4b_par", 32'(mdl[i].par), 32'd0);

    // T2: frame 1,0,1,1 with free-flowing output
    model(4, 1'b1, 4'b1101);
    enqueue_model();
    drive_bit(1'b1, 1'b0);
    chk("t2_busy", 32'(busy), 32'd1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b1);
    wait_drain("t2");

    // T3: same frame with out_ready toggling
    tog = 1;
    model(4, 1'b1, 4'b1101);
    enqueue_model();
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b1);
    wait_drain("t3");
    tog = 0;

    // T4: single-bit frame "1" then back-to-back frame "0"
    model(1, 1'b1, 4'b0001);
    enqueue_model();
    model(1, 1'b1, 4'b0000);
    enqueue_model();
    drive_bit(1'b1, 1'b1);
    chk("t4_busy_tail", 32'(busy), 32'd1);
    chk("t4_in_ready_tail", 32'(in_ready), 32'd0);
    drive_bit(1'b0, 1'b1);
    wait_drain("t4");

    // T5: reset mid-frame; third symbol is still in the register when RST hits
    model(2, 1'b0, 4'b0101);
    enqueue_model();
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("t5_flushed", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    model(1, 1'b1, 4'b0001);
    enqueue_model();
    drive_bit(1'b1, 1'b1);
    wait_drain("t5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
